// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM states, funct3 encodings and access-size decode.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2,
      S_DONE   = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } acc_size_e;

   // Undefined encodings fall through to word size.
   function automatic acc_size_e f3_size(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LBU: return SZ_BYTE;
         F3_LH, F3_LHU: return SZ_HALF;
         F3_LW:         return SZ_WORD;
         default:       return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/response bus between the LSU and the memory.
interface lsu_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wstrb;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      input  dm_gnt, dm_rvalid, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      output dm_gnt, dm_rvalid, dm_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobe/data, misalign check, load extract.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_off,
   input  logic [2:0]  st_funct3,
   input  logic [31:0] st_data,
   input  logic [1:0]  ld_off,
   input  logic [2:0]  ld_funct3,
   input  logic [31:0] ld_word,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        misalign
);

   acc_size_e  st_sz;
   acc_size_e  ld_sz;
   logic       ld_signed;
   logic [7:0] ld_byte;
   logic [15:0] ld_half;

   assign st_sz     = f3_size(st_funct3);
   assign ld_sz     = f3_size(ld_funct3);
   assign ld_signed = ~ld_funct3[2];

   // Store lanes and alignment are judged on the live (execute-side) address.
   always_comb begin
      wstrb    = 4'b1111;
      wdata    = st_data;
      misalign = 1'b0;
      case (st_sz)
         SZ_BYTE: begin
            wstrb = 4'b0001 << st_off;
            wdata = {4{st_data[7:0]}};
         end
         SZ_HALF: begin
            wstrb    = 4'b0011 << {st_off[1], 1'b0};
            wdata    = {2{st_data[15:0]}};
            misalign = st_off[0];
         end
         default: misalign = |st_off;
      endcase
   end

   // Load lanes use the offset/funct3 latched when the request was issued.
   always_comb begin
      case (ld_off)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_sz)
         SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding data-memory access, stalls the pipe while busy.
module lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [31:0] i_ALUout,
   input  logic [31:0] i_rs2_data,
   input  logic [2:0]  i_funct3,
   input  logic        i_DM_OE,
   input  logic        i_DM_WE,
   input  logic [4:0]  i_rd_addr,
   input  logic        i_rd_wr,
   lsu_if.master       dm,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_ALUout,
   output logic        o_rd_wr,
   output logic        o_DM_OE,
   output logic [31:0] o_DM_data,
   output logic        o_stall,
   output logic        o_misalign
);

   lsu_state_e  state, state_nxt;
   logic        mem_op, mis_det, start, capture, req;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata, al_ld_data;
   logic        al_mis;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        we_q;
   logic [3:0]  wstrb_q;
   logic [31:0] addr_q, wdata_q, dm_data_q;

   lsu_align u_align (
      .st_off    (i_ALUout[1:0]),
      .st_funct3 (i_funct3),
      .st_data   (i_rs2_data),
      .ld_off    (off_q),
      .ld_funct3 (f3_q),
      .ld_word   (dm.dm_rdata),
      .wstrb     (al_wstrb),
      .wdata     (al_wdata),
      .ld_data   (al_ld_data),
      .misalign  (al_mis)
   );

   assign mem_op  = i_valid & (i_DM_OE | i_DM_WE);
   assign mis_det = mem_op & al_mis;
   // Only IDLE accepts a new op; in DONE the stalled op is still on the inputs.
   assign start   = (state == S_IDLE) & mem_op & ~al_mis;

   // State register; reset drops any in-flight access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next state and control outputs; reset gates the combinational input paths.
   always_comb begin
      state_nxt  = state;
      capture    = 1'b0;
      req        = 1'b0;
      o_stall    = 1'b0;
      o_misalign = 1'b0;
      case (state)
         S_IDLE: begin
            o_stall    = rst & start;
            o_misalign = rst & mis_det;
            if (start) state_nxt = S_REQ;
         end
         S_REQ: begin
            req     = 1'b1;
            o_stall = 1'b1;
            if (dm.dm_gnt) state_nxt = we_q ? S_DONE : S_WAIT_R;
         end
         S_WAIT_R: begin
            o_stall = 1'b1;
            if (dm.dm_rvalid) begin
               capture   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request fields are frozen at issue so the bus stays stable until grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'b0000;
         we_q      <= 1'b0;
         off_q     <= 2'b00;
         f3_q      <= 3'b000;
         dm_data_q <= 32'h0;
      end else begin
         if (start) begin
            addr_q  <= {i_ALUout[31:2], 2'b00};
            off_q   <= i_ALUout[1:0];
            f3_q    <= i_funct3;
            we_q    <= i_DM_WE;
            wstrb_q <= i_DM_WE ? al_wstrb : 4'b0000;
            wdata_q <= i_DM_WE ? al_wdata : 32'h0;
         end
         if (capture) dm_data_q <= al_ld_data;
      end
   end

   assign dm.dm_req   = req;
   assign dm.dm_we    = we_q;
   assign dm.dm_addr  = addr_q;
   assign dm.dm_wdata = wdata_q;
   assign dm.dm_wstrb = wstrb_q;

   assign o_rd_addr = i_rd_addr;
   assign o_ALUout  = i_ALUout;
   assign o_DM_OE   = i_DM_OE;
   assign o_rd_wr   = i_valid & i_rd_wr & ~mis_det;
   assign o_DM_data = dm_data_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single accesses plus corner sequences.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_DM_OE, i_DM_WE, i_rd_wr;
   logic [31:0] i_ALUout, i_rs2_data;
   logic [2:0]  i_funct3;
   logic [4:0]  i_rd_addr;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_ALUout, o_DM_data;
   logic        o_rd_wr, o_DM_OE, o_stall, o_misalign;

   lsu_if dm_bus();

   lsu dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_ALUout(i_ALUout), .i_rs2_data(i_rs2_data),
      .i_funct3(i_funct3), .i_DM_OE(i_DM_OE), .i_DM_WE(i_DM_WE),
      .i_rd_addr(i_rd_addr), .i_rd_wr(i_rd_wr),
      .dm(dm_bus),
      .o_rd_addr(o_rd_addr), .o_ALUout(o_ALUout), .o_rd_wr(o_rd_wr),
      .o_DM_OE(o_DM_OE), .o_DM_data(o_DM_data),
      .o_stall(o_stall), .o_misalign(o_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      logic        mis;
      logic [3:0]  x_wstrb;
      logic [31:0] x_wdata;
      logic [31:0] x_addr;
      logic [31:0] x_ld;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs[NV];
   vec_t v;
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic vec_t mk(input string nm, input logic [2:0] f3, input logic we,
                               input logic [31:0] addr, data, rdata, input logic mis,
                               input logic [3:0] xs, input logic [31:0] xw, xa, xl);
      vec_t r;
      r.name = nm; r.f3 = f3; r.we = we; r.addr = addr; r.data = data; r.rdata = rdata;
      r.mis = mis; r.x_wstrb = xs; r.x_wdata = xw; r.x_addr = xa; r.x_ld = xl;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            name       f3      we    addr          data          rdata         mis   wstrb  wdata         addr          load
      vecs[0]  = mk("sw",      3'b010, 1'b1, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0000_0100, 32'h0);
      vecs[1]  = mk("sb103",   3'b000, 1'b1, 32'h0000_0103, 32'h0000_00A5, 32'h0,       1'b0, 4'h8, 32'hA5A5A5A5, 32'h0000_0100, 32'h0);
      vecs[2]  = mk("sh102",   3'b001, 1'b1, 32'h0000_0102, 32'h1234BEEF, 32'h0,        1'b0, 4'hC, 32'hBEEFBEEF, 32'h0000_0100, 32'h0);
      vecs[3]  = mk("sb201",   3'b000, 1'b1, 32'h0000_0201, 32'h77665544, 32'h0,        1'b0, 4'h2, 32'h44444444, 32'h0000_0200, 32'h0);
      vecs[4]  = mk("lb102",   3'b000, 1'b0, 32'h0000_0102, 32'h0,        32'h00800000, 1'b0, 4'h0, 32'h0,        32'h0000_0100, 32'hFFFFFF80);
      vecs[5]  = mk("lbu102",  3'b100, 1'b0, 32'h0000_0102, 32'h0,        32'h00800000, 1'b0, 4'h0, 32'h0,        32'h0000_0100, 32'h00000080);
      vecs[6]  = mk("lh102",   3'b001, 1'b0, 32'h0000_0102, 32'h0,        32'h80010000, 1'b0, 4'h0, 32'h0,        32'h0000_0100, 32'hFFFF8001);
      vecs[7]  = mk("lhu100",  3'b101, 1'b0, 32'h0000_0100, 32'h0,        32'h1234F00D, 1'b0, 4'h0, 32'h0,        32'h0000_0100, 32'h0000F00D);
      vecs[8]  = mk("lw104",   3'b010, 1'b0, 32'h0000_0104, 32'h0,        32'hCAFEBABE, 1'b0, 4'h0, 32'h0,        32'h0000_0104, 32'hCAFEBABE);
      vecs[9]  = mk("sf3_111", 3'b111, 1'b1, 32'h0000_0108, 32'h11223344, 32'h0,        1'b0, 4'hF, 32'h11223344, 32'h0000_0108, 32'h0);
      vecs[10] = mk("lw_mis",  3'b010, 1'b0, 32'h0000_0102, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,         32'h0);
      vecs[11] = mk("sh_mis",  3'b001, 1'b1, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,         32'h0);
      vecs[12] = mk("lf3_011", 3'b011, 1'b0, 32'h0000_010A, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,         32'h0);
      vecs[13] = mk("lb103",   3'b000, 1'b0, 32'h0000_0103, 32'h0,        32'h7F000000, 1'b0, 4'h0, 32'h0,        32'h0000_0100, 32'h0000007F);

      // Reset with an aligned load presented: control outputs must stay quiet.
      rst = 1'b0;
      i_valid = 1'b1; i_DM_OE = 1'b1; i_DM_WE = 1'b0; i_rd_wr = 1'b1;
      i_ALUout = 32'h100; i_rs2_data = 32'h0; i_funct3 = F3_LW; i_rd_addr = 5'd1;
      dm_bus.dm_gnt = 1'b0; dm_bus.dm_rvalid = 1'b0; dm_bus.dm_rdata = 32'h0;
      #2;
      chk("rst.stall",    o_stall, 0);
      chk("rst.req",      dm_bus.dm_req, 0);
      chk("rst.we",       dm_bus.dm_we, 0);
      chk("rst.wstrb",    dm_bus.dm_wstrb, 0);
      chk("rst.misalign", o_misalign, 0);
      chk("rst.addr",     dm_bus.dm_addr, 0);
      chk("rst.wdata",    dm_bus.dm_wdata, 0);
      chk("rst.ld_data",  o_DM_data, 0);
      i_valid = 1'b0;
      step();
      rst = 1'b1;

      // Non-memory instruction passes straight through.
      step();
      i_valid = 1'b1; i_DM_OE = 1'b0; i_DM_WE = 1'b0; i_rd_wr = 1'b1;
      i_rd_addr = 5'd7; i_ALUout = 32'h12345678;
      @(negedge clk);
      chk("alu.stall",   o_stall, 0);
      chk("alu.rd_wr",   o_rd_wr, 1);
      chk("alu.rd_addr", o_rd_addr, 32'd7);
      chk("alu.aluout",  o_ALUout, 32'h12345678);
      chk("alu.req",     dm_bus.dm_req, 0);
      step();
      i_valid = 1'b0;
      @(negedge clk);
      chk("inv.rd_wr", o_rd_wr, 0);

      // Table: immediate grant, read data in the first WAIT_R cycle.
      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         step();
         i_valid = 1'b1; i_funct3 = v.f3; i_ALUout = v.addr; i_rs2_data = v.data;
         i_DM_WE = v.we; i_DM_OE = ~v.we; i_rd_wr = 1'b1; i_rd_addr = 5'(i + 1);
         @(negedge clk);
         chk({v.name, ".misalign"}, o_misalign, v.mis);
         chk({v.name, ".stall0"},   o_stall, !v.mis);
         chk({v.name, ".rd_wr"},    o_rd_wr, !v.mis);
         chk({v.name, ".oe"},       o_DM_OE, !v.we);
         if (v.mis) begin
            chk({v.name, ".req_idle"}, dm_bus.dm_req, 0);
            step();
            i_valid = 1'b0;
            @(negedge clk);
            chk({v.name, ".req_after"}, dm_bus.dm_req, 0);
            chk({v.name, ".mis_after"}, o_misalign, 0);
         end else begin
            step();
            dm_bus.dm_gnt = 1'b1;
            @(negedge clk);
            chk({v.name, ".req"},   dm_bus.dm_req, 1);
            chk({v.name, ".stall1"}, o_stall, 1);
            chk({v.name, ".addr"},  dm_bus.dm_addr, v.x_addr);
            chk({v.name, ".wstrb"}, dm_bus.dm_wstrb, v.x_wstrb);
            chk({v.name, ".wdata"}, dm_bus.dm_wdata, v.x_wdata);
            chk({v.name, ".we"},    dm_bus.dm_we, v.we);
            step();
            dm_bus.dm_gnt = 1'b0;
            if (!v.we) begin
               dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = v.rdata;
               @(negedge clk);
               chk({v.name, ".stall_w"}, o_stall, 1);
               chk({v.name, ".req_w"},   dm_bus.dm_req, 0);
               step();
               dm_bus.dm_rvalid = 1'b0;
            end
            @(negedge clk);
            chk({v.name, ".stall_done"}, o_stall, 0);
            chk({v.name, ".req_done"},   dm_bus.dm_req, 0);
            if (!v.we) chk({v.name, ".ld_data"}, o_DM_data, v.x_ld);
            step();
            i_valid = 1'b0;
         end
      end

      // Load with grant held off 3 cycles, rvalid in the grant cycle ignored,
      // real read data 2 cycles after grant.
      step();
      i_valid = 1'b1; i_funct3 = F3_LW; i_ALUout = 32'h10C; i_DM_OE = 1'b1; i_DM_WE = 1'b0;
      i_rd_wr = 1'b1; i_rd_addr = 5'd3;
      @(negedge clk);
      chk("dly.stall_idle", o_stall, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         chk("dly.req_hold",   dm_bus.dm_req, 1);
         chk("dly.addr_hold",  dm_bus.dm_addr, 32'h10C);
         chk("dly.we_hold",    dm_bus.dm_we, 0);
         chk("dly.stall_hold", o_stall, 1);
      end
      step();
      dm_bus.dm_gnt = 1'b1; dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'h55555555;
      @(negedge clk);
      chk("dly.req_gnt",  dm_bus.dm_req, 1);
      chk("dly.addr_gnt", dm_bus.dm_addr, 32'h10C);
      step();
      dm_bus.dm_gnt = 1'b0; dm_bus.dm_rvalid = 1'b0;
      @(negedge clk);
      chk("dly.req_w1",   dm_bus.dm_req, 0);
      chk("dly.stall_w1", o_stall, 1);
      step();
      dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'h89ABCDEF;
      @(negedge clk);
      chk("dly.stall_w2", o_stall, 1);
      step();
      dm_bus.dm_rvalid = 1'b0;
      @(negedge clk);
      chk("dly.stall_done", o_stall, 0);
      chk("dly.ld_data",    o_DM_data, 32'h89ABCDEF);
      step();
      i_valid = 1'b0;
      dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'h0;
      @(negedge clk);
      chk("dly.stall_idle2", o_stall, 0);
      step();
      dm_bus.dm_rvalid = 1'b0;
      @(negedge clk);
      chk("dly.ld_hold", o_DM_data, 32'h89ABCDEF);

      // Misaligned halfword store.
      step();
      i_valid = 1'b1; i_funct3 = F3_LH; i_ALUout = 32'h101; i_rs2_data = 32'h0000BEEF;
      i_DM_OE = 1'b0; i_DM_WE = 1'b1; i_rd_wr = 1'b1;
      @(negedge clk);
      chk("shmis.misalign", o_misalign, 1);
      chk("shmis.stall",    o_stall, 0);
      chk("shmis.rd_wr",    o_rd_wr, 0);
      chk("shmis.req",      dm_bus.dm_req, 0);
      step();
      i_valid = 1'b0;
      @(negedge clk);
      chk("shmis.pulse_end", o_misalign, 0);
      chk("shmis.req_next",  dm_bus.dm_req, 0);

      // Reset in WAIT_R abandons the load; a stale rvalid afterwards is dropped.
      step();
      i_valid = 1'b1; i_funct3 = F3_LW; i_ALUout = 32'h110; i_DM_OE = 1'b1; i_DM_WE = 1'b0;
      @(negedge clk);
      chk("rstw.stall_idle", o_stall, 1);
      step();
      dm_bus.dm_gnt = 1'b1;
      @(negedge clk);
      chk("rstw.req", dm_bus.dm_req, 1);
      step();
      dm_bus.dm_gnt = 1'b0;
      @(negedge clk);
      chk("rstw.in_wait", o_stall, 1);
      #1;
      rst = 1'b0;
      #1;
      chk("rstw.req0",    dm_bus.dm_req, 0);
      chk("rstw.stall0",  o_stall, 0);
      chk("rstw.addr0",   dm_bus.dm_addr, 0);
      chk("rstw.ldata0",  o_DM_data, 0);
      step();
      i_valid = 1'b0;
      rst = 1'b1;
      dm_bus.dm_rvalid = 1'b1; dm_bus.dm_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("rstw.req_rel",   dm_bus.dm_req, 0);
      chk("rstw.stall_rel", o_stall, 0);
      step();
      dm_bus.dm_rvalid = 1'b0;
      @(negedge clk);
      chk("rstw.stale_rvalid", o_DM_data, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL have a port clk, input, 1 bit: the single clock, rising edge.
REQ-002 The module SHALL have a port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have the following execute-side input ports:
- i_valid, 1 bit: an instruction is present.
- i_ALUout, 32 bits: ALU result, also the effective address.
- i_rs2_data, 32 bits: store data.
- i_funct3, 3 bits: access size and sign.
- i_DM_OE, 1 bit: load.
- i_DM_WE, 1 bit: store.
- i_rd_addr, 5 bits.
- i_rd_wr, 1 bit.
REQ-004 The module SHALL have the following data-memory port signals:
- dm_req, output, 1 bit.
- dm_we, output, 1 bit.
- dm_addr, output, 32 bits, word-aligned.
- dm_wdata, output, 32 bits.
- dm_wstrb, output, 4 bits.
- dm_gnt, input, 1 bit: request accepted.
- dm_rvalid, input, 1 bit.
- dm_rdata, input, 32 bits.
REQ-005 The module SHALL have the following writeback-side output ports:
- o_rd_addr, 5 bits.
- o_ALUout, 32 bits.
- o_rd_wr, 1 bit.
- o_DM_OE, 1 bit.
- o_DM_data, 32 bits: aligned and extended load data.
REQ-006 The module SHALL have the following control output ports:
- o_stall, 1 bit: freezes all upstream stages and the downstream pipeline register.
- o_misalign, 1 bit: exception pulse.

Function
REQ-007 The module SHALL implement a state machine with states IDLE, REQ, WAIT_R and DONE.
REQ-008 In IDLE, a non-memory instruction (i_valid with neither i_DM_OE nor i_DM_WE) SHALL pass through combinationally with zero added latency, and o_stall SHALL be 0.
REQ-009 In IDLE, an aligned memory operation with i_valid SHALL assert o_stall combinationally in the same cycle.
REQ-010 The module SHALL register address, strobe, wdata and we on that edge and go to REQ.
REQ-011 In REQ, the module SHALL hold dm_req=1 with stable dm_addr, dm_we, dm_wdata and dm_wstrb until a cycle with dm_gnt=1.
REQ-012 On grant, a store SHALL go to DONE and a load SHALL go to WAIT_R; dm_req SHALL be 0 from the next cycle.
REQ-013 In WAIT_R, the module SHALL wait for dm_rvalid, capture the extended dm_rdata into o_DM_data, and go to DONE.
REQ-014 A dm_rvalid arriving in the same cycle as dm_gnt SHALL be ignored; read data SHALL be accepted only in WAIT_R.
REQ-015 DONE SHALL last exactly one cycle, with o_stall=0 so the pipeline advances, and SHALL then go to IDLE.
REQ-016 Stall behaviour SHALL be: o_stall=1 in REQ and WAIT_R, and in IDLE while an aligned memory op is presented.
REQ-017 Minimum store latency SHALL be 3 cycles (IDLE, REQ with gnt, DONE).
REQ-018 Minimum load latency SHALL be 4 cycles.
REQ-019 Store formatting SHALL be:
- SB: wstrb = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
- SH: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = half replicated ×2.
- SW: wstrb = 4'b1111.
REQ-020 Load extraction SHALL select the byte or half by addr[1:0], sign-extend for LB/LH and zero-extend for LBU/LHU; LW SHALL pass the word unchanged.
REQ-021 A misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0) SHALL issue no dm_req and pulse o_misalign for one cycle.
REQ-022 On a misaligned access, o_rd_wr SHALL be forced to 0 and o_stall SHALL remain 0.
REQ-023 o_rd_addr, o_ALUout, o_rd_wr and o_DM_OE SHALL mirror the inputs combinationally.
REQ-024 o_rd_wr SHALL be 0 whenever i_valid=0 or a misalign is detected.
REQ-025 o_DM_data SHALL hold its last captured value outside DONE.
REQ-026 Undefined funct3 values on a memory op SHALL be treated as word size.

Reset
REQ-027 While rst=0, the state SHALL be IDLE, and dm_req, dm_we, dm_wstrb, o_stall and o_misalign SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 While rst=0, dm_addr, dm_wdata and o_DM_data SHALL be 32'h0.
REQ-029 A reset asserted in REQ or WAIT_R SHALL abandon the transaction; a dm_rvalid arriving after reset release in IDLE SHALL be ignored.

Structure
REQ-030 A shared package lsu_pkg SHALL hold the state enum and the funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101).
REQ-031 A combinational sub-module lsu_align SHALL generate the store strobe and data, perform load extraction and extension, and detect misalignment.

Verification
REQ-032 The bench SHALL check: SW addr 0x100, data 0xDEADBEEF, gnt immediate → dm_wstrb=1111, o_stall high 2 cycles, DONE in cycle 3.
REQ-033 The bench SHALL check: SB addr 0x103, data 0x000000A5 → dm_wstrb=1000, dm_wdata=0xA5A5A5A5, dm_addr=0x100.
REQ-034 The bench SHALL check: LB addr 0x102, dm_rdata 0x00800000 → o_DM_data=0xFFFFFF80; LBU on the same data → 0x00000080.
REQ-035 The bench SHALL check: LW with dm_gnt delayed 3 cycles and rvalid 2 cycles later → dm_req held stable throughout, o_stall low only in DONE.
REQ-036 The bench SHALL check: SH addr 0x101 → no dm_req, o_misalign one-cycle pulse, o_rd_wr=0, o_stall=0.
REQ-037 The bench SHALL check: rst asserted in WAIT_R → dm_req=0 and IDLE immediately, and a stale dm_rvalid after release leaves o_DM_data=0.
